// File: rtl/light_phase_ctrl.sv
// Phase sequencer for the crossroad traffic light.
// Steps the NS/EW lamp sets through green, yellow and all-red, drives the
// seconds countdown for the display path, and adds night flashing-yellow
// and emergency all-red override modes. All outputs are registered.
module light_phase_ctrl #(
    parameter int G_NS    = 30,
    parameter int G_EW    = 25,
    parameter int Y_TIME  = 3,
    parameter int AR_TIME = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       night,
    input  logic       emerg,
    output logic [5:0] count,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        AR1   = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        AR2   = 3'd5,
        NIGHT = 3'd6,
        EMERG = 3'd7
    } state_t;

    localparam logic [5:0] DUR_NS = 6'(G_NS);
    localparam logic [5:0] DUR_EW = 6'(G_EW);
    localparam logic [5:0] DUR_Y  = 6'(Y_TIME);
    localparam logic [5:0] DUR_AR = 6'(AR_TIME);

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    state_t     state_q, state_d;
    logic [5:0] count_q, count_d;
    logic       blink_q, blink_d;
    logic [2:0] ns_q, ns_d;
    logic [2:0] ew_q, ew_d;

    // Next state, countdown and blink: emergency first, then night, then timed progression.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        blink_d = blink_q;
        if (emerg) begin
            state_d = EMERG;
            count_d = 6'd0;
        end else begin
            case (state_q)
                EMERG: begin
                    state_d = AR2;
                    count_d = DUR_AR;
                end
                NIGHT: begin
                    if (tick) begin
                        if (!night) begin
                            state_d = AR2;
                            count_d = DUR_AR;
                        end else begin
                            blink_d = ~blink_q;
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        if (night && (state_q == NS_G || state_q == EW_G)) begin
                            state_d = (state_q == NS_G) ? NS_Y : EW_Y;
                            count_d = DUR_Y;
                        end else if (count_q > 6'd1) begin
                            count_d = count_q - 6'd1;
                        end else if (night) begin
                            state_d = NIGHT;
                            count_d = 6'd0;
                            blink_d = 1'b1;
                        end else begin
                            case (state_q)
                                NS_G: begin
                                    state_d = NS_Y;
                                    count_d = DUR_Y;
                                end
                                NS_Y: begin
                                    state_d = AR1;
                                    count_d = DUR_AR;
                                end
                                AR1: begin
                                    state_d = EW_G;
                                    count_d = DUR_EW;
                                end
                                EW_G: begin
                                    state_d = EW_Y;
                                    count_d = DUR_Y;
                                end
                                EW_Y: begin
                                    state_d = AR2;
                                    count_d = DUR_AR;
                                end
                                default: begin
                                    state_d = NS_G;
                                    count_d = DUR_NS;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Lamp decode from the upcoming state so lamps change together with the state.
    always_comb begin
        ns_d = LAMP_R;
        ew_d = LAMP_R;
        case (state_d)
            NS_G: ns_d = LAMP_G;
            NS_Y: ns_d = LAMP_Y;
            EW_G: ew_d = LAMP_G;
            EW_Y: ew_d = LAMP_Y;
            NIGHT: begin
                ns_d = blink_d ? LAMP_Y : LAMP_OFF;
                ew_d = blink_d ? LAMP_Y : LAMP_OFF;
            end
            default: begin
                ns_d = LAMP_R;
                ew_d = LAMP_R;
            end
        endcase
    end

    // State, countdown, blink and lamp registers with synchronous reset to NS green.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NS_G;
            count_q <= DUR_NS;
            blink_q <= 1'b1;
            ns_q    <= LAMP_G;
            ew_q    <= LAMP_R;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            blink_q <= blink_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
        end
    end

    assign count    = count_q;
    assign ns_light = ns_q;
    assign ew_light = ew_q;
    assign phase    = state_q;

endmodule
